// File: rtl/shift_stream.sv
// shift_stream: serializes a parallel load of DEPTH words onto a valid/ready stream, MSB- or LSB-word first.
module shift_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH*DEPTH-1:0]     i_data,
  input  logic [$clog2(DEPTH+1)-1:0] i_len,
  input  logic                       i_lsb_first,
  input  logic                       i_req,
  input  logic                       i_abort,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH*DEPTH-1:0] data_buf;
  logic lsb_first;
  logic [CW-1:0] len, cnt, eff_len, first_idx, next_idx;
  function automatic logic [WIDTH-1:0] word(input logic [WIDTH*DEPTH-1:0] v, input logic [CW-1:0] k);
    logic [WIDTH*DEPTH-1:0] s;
    s = v >> (int'(k) * WIDTH);
    return s[WIDTH-1:0];
  endfunction
  // cnt is the number of words already presented, so it also indexes the next word
  always_comb begin
    eff_len = (i_len > CW'(DEPTH)) ? CW'(DEPTH) : i_len;
    first_idx = i_lsb_first ? '0 : eff_len - CW'(1);
    next_idx = lsb_first ? cnt : len - cnt - CW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data_buf <= '0;
      lsb_first <= 1'b0;
      len <= '0;
      cnt <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_last <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_req && eff_len != '0) begin
          state <= SHIFT;
          data_buf <= i_data;
          lsb_first <= i_lsb_first;
          len <= eff_len;
          cnt <= CW'(1);
          o_data <= word(i_data, first_idx);
          o_valid <= 1'b1;
          o_last <= (eff_len == CW'(1));
          o_busy <= 1'b1;
        end
      end else if (i_abort || (i_ready && o_last)) begin
        state <= IDLE;
        cnt <= '0;
        o_data <= '0;
        o_valid <= 1'b0;
        o_last <= 1'b0;
        o_busy <= 1'b0;
        o_done <= !i_abort;
      end else if (i_ready) begin
        o_data <= word(data_buf, next_idx);
        o_last <= (cnt == len - CW'(1));
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_shift_stream.sv
// tb_shift_stream: directed and random checks of shift_stream against a queue-based burst model.
module tb_shift_stream;
  localparam int W = 8, D = 8;
  localparam logic [W*D-1:0] VEC = 64'h1234567812345678;
  logic clk = 1'b0, rst = 1'b1;
  logic [W*D-1:0] i_data = '0;
  logic [3:0] i_len = '0;
  logic i_lsb_first = 1'b0, i_req = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
  logic [W-1:0] o_data;
  logic o_valid, o_last, o_busy, o_done;
  int n_checks = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic m_done = 1'b0;

  shift_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_len(i_len), .i_lsb_first(i_lsb_first),
    .i_req(i_req), .i_abort(i_abort), .i_ready(i_ready), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, W'(o_valid), W'(q.size() != 0));
    chk({tag, ".data"}, o_data, (q.size() != 0) ? q[0] : '0);
    chk({tag, ".last"}, W'(o_last), W'(q.size() == 1));
    chk({tag, ".busy"}, W'(o_busy), W'(q.size() != 0));
    chk({tag, ".done"}, W'(o_done), W'(m_done));
  endtask

  // one clock: drive at negedge, advance the model at posedge, check at the next negedge
  task automatic cyc(input logic [W*D-1:0] data, input logic req, input int len, input logic lsb,
                     input logic abort, input logic ready, input string tag);
    int eff;
    i_data = data; i_req = req; i_len = 4'(len); i_lsb_first = lsb; i_abort = abort; i_ready = ready;
    @(posedge clk);
    m_done = 1'b0;
    if (q.size() == 0) begin
      if (req && len != 0) begin
        eff = (len > D) ? D : len;
        for (int i = 0; i < eff; i++) q.push_back(data[(lsb ? i : eff - 1 - i) * W +: W]);
      end
    end else if (abort) q.delete();
    else if (ready) begin
      void'(q.pop_front());
      if (q.size() == 0) m_done = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #2 check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc(VEC, 1, 8, 0, 0, 1, "msb8");
    for (int i = 0; i < 9; i++) cyc(VEC, 0, 8, 0, 0, 1, "msb8");
    cyc(VEC, 1, 3, 1, 0, 1, "lsb3");
    for (int i = 0; i < 4; i++) cyc(VEC, 0, 3, 1, 0, 1, "lsb3");
    cyc(VEC, 1, 8, 0, 0, 1, "stall");
    cyc(VEC, 0, 8, 0, 0, 0, "stall");
    cyc(VEC, 0, 8, 0, 0, 0, "stall");
    for (int i = 0; i < 9; i++) cyc(VEC, 0, 8, 0, 0, 1, "stall");
    cyc(VEC, 1, 8, 0, 0, 1, "abort");
    cyc(VEC, 0, 8, 0, 0, 1, "abort");
    cyc(VEC, 0, 8, 0, 1, 1, "abort");
    cyc(VEC, 0, 8, 0, 0, 1, "abort");
    cyc(VEC, 1, 8, 0, 0, 1, "restart");
    for (int i = 0; i < 9; i++) cyc(VEC, 0, 8, 0, 0, 1, "restart");
    cyc(VEC, 1, 8, 0, 0, 1, "rst_mid");
    cyc(VEC, 0, 8, 0, 0, 1, "rst_mid");
    i_req = 1'b0;
    rst = 1'b1;
    #1 q.delete();
    m_done = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    rst = 1'b0;
    cyc(VEC, 1, 8, 0, 0, 1, "after_rst");
    for (int i = 0; i < 9; i++) cyc(VEC, 0, 8, 0, 0, 1, "after_rst");
    cyc(VEC, 1, 0, 0, 0, 1, "len0");
    cyc(VEC, 1, 0, 1, 0, 1, "len0");
    cyc(VEC, 1, 12, 0, 0, 1, "len12");
    for (int i = 0; i < 9; i++) cyc(VEC, 0, 12, 0, 0, 1, "len12");
    cyc(VEC, 1, 8, 0, 0, 1, "req_busy");
    for (int i = 0; i < 7; i++) cyc(~VEC, 1, 2, 1, 0, 1, "req_busy");
    cyc(VEC, 1, 1, 1, 0, 1, "b2b");
    cyc(VEC, 1, 1, 0, 0, 1, "b2b");
    cyc(VEC, 0, 1, 0, 0, 1, "b2b");
    cyc(VEC, 1, 2, 1, 0, 1, "abort_last");
    cyc(VEC, 0, 2, 1, 0, 1, "abort_last");
    cyc(VEC, 0, 2, 1, 1, 1, "abort_last");
    cyc(VEC, 0, 2, 1, 0, 1, "abort_last");
    cyc(VEC, 1, 4, 0, 1, 1, "abort_req");
    for (int i = 0; i < 4; i++) cyc(VEC, 0, 4, 0, 0, 1, "abort_req");
    for (int i = 0; i < 600; i++)
      cyc({$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_stream.md
SHIFT_STREAM -- requirements
Module: shift_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per output word; legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 8: number of words in the parallel input; legal range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_data, input, WIDTH*DEPTH bits: parallel load word; word k = i_data[k*WIDTH +: WIDTH].
REQ-006 SHALL have port i_len, input, $clog2(DEPTH+1) bits: number of words to send.
REQ-007 SHALL have port i_lsb_first, input, 1 bit: order select; 1 = word 0 first, 0 = highest word first.
REQ-008 SHALL have port i_req, input, 1 bit: start request, active-high.
REQ-009 SHALL have port i_abort, input, 1 bit: cancel the current burst.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream ready.
REQ-011 SHALL have port o_data, output, WIDTH bits: current word.
REQ-012 SHALL have port o_valid, output, 1 bit: o_data is valid.
REQ-013 SHALL have port o_last, output, 1 bit: current word is the final word of the burst.
REQ-014 SHALL have port o_busy, output, 1 bit: a burst is in progress.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse on burst completion.

Function
REQ-016 SHALL implement two states, IDLE and SHIFT.
REQ-017 IDLE -> SHIFT SHALL occur when i_req=1 and eff_len!=0 at a clock edge; on that edge the block captures i_data, i_lsb_first and eff_len into internal registers.
REQ-018 eff_len SHALL be min(i_len, DEPTH); i_len=0 SHALL be ignored, with the block staying in IDLE and no output change.
REQ-019 i_req, i_data, i_len and i_lsb_first SHALL be ignored while in SHIFT; the captured copies alone drive the burst.
REQ-020 Latency: o_valid SHALL rise on the cycle after the capturing edge, with the first word on o_data.
REQ-021 Send order SHALL be: MSB-first sends words eff_len-1 down to 0; LSB-first sends words 0 up to eff_len-1; words at index eff_len and above are never sent.
REQ-022 A transfer SHALL occur on an edge where o_valid=1 and i_ready=1; each transfer advances to the next word.
REQ-023 While i_ready=0, o_data, o_valid and o_last SHALL hold stable; there is no limit on stall length.
REQ-024 o_last SHALL equal 1 exactly while the final word is presented.
REQ-025 After the final transfer, the block SHALL go to IDLE on that edge; o_valid, o_last and o_busy drop, and o_done=1 for exactly the next cycle.
REQ-026 o_busy SHALL be 1 throughout SHIFT, and 0 in IDLE.
REQ-027 o_data SHALL be 0 whenever o_valid=0.
REQ-028 i_abort=1 in SHIFT SHALL cause a return to IDLE on that edge; no o_done pulse follows; abort has priority over a coincident transfer, including the final one.
REQ-029 i_abort in IDLE SHALL have no effect.
REQ-030 i_abort=1 together with i_req=1 in IDLE SHALL start the burst normally.
REQ-031 A new i_req SHALL be accepted in the same cycle that o_done=1, which gives back-to-back bursts with one idle output cycle.
REQ-032 The word counter SHALL be $clog2(DEPTH+1) bits wide and SHALL never wrap; no word is sent twice.

Reset
REQ-033 While rst=1, the block SHALL be in IDLE with o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0, and internal buffer and counters at 0.
REQ-034 rst asserted mid-burst SHALL abandon the burst immediately and asynchronously, with no o_done pulse.
REQ-035 After rst falls, the block SHALL accept i_req from the first rising clk edge onward.

Verification (WIDTH=8, DEPTH=8, i_data=64'h1234567812345678)
REQ-036 MSB-first, i_len=8, i_ready=1, i_req at edge 0 -> o_valid on cycles 1-8 with data 12,34,56,78,12,34,56,78; o_last on cycle 8; o_done on cycle 9; o_busy on cycles 1-8.
REQ-037 LSB-first, i_len=3 -> 78,56,34; o_last with 34; o_done 1 cycle later.
REQ-038 MSB-first, i_len=8, i_ready=0 on cycles 2-3 -> 34 held on cycles 2-4; last word on cycle 10; o_done on cycle 11.
REQ-039 i_abort pulsed on cycle 3 -> o_valid=0 from cycle 4; no o_done; i_req on cycle 5 starts a fresh burst with 12 first.
REQ-040 rst pulsed mid-burst -> all outputs 0 immediately; burst lost; the next i_req behaves as in REQ-036.
REQ-041 i_len=0 -> no activity; i_len=12 -> 8 words sent; i_req during a burst -> ignored, with output identical to REQ-036.
